handle_mark: RTL and testbench
==============================

HANDLE_MARK -- requirements
Module: handle_mark

Interface
REQ-001 Parameter: WIN_LINES, default 5, number of completed lines that raises win.
REQ-002 clk  input  1  sole clock, all logic on posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 interboard_rst  input  1  synchronous, active-high reset, identical effect to rst.
REQ-005 start_game  input  1  clear all marks and results, abort any in-flight mark.
REQ-006 mark_valid  input  1  single-cycle request to mark mark_number_BCD.
REQ-007 mark_number_BCD  input  8  called number; [7:4] tens digit, [3:0] units digit.
REQ-008 num_to_pos  input  125  number n (1..25) maps to board position in bits [(n-1)*5 +: 5]; positions 0..24 row-major.
REQ-009 marked  output  25  bit p set means position p is marked.
REQ-010 busy  output  1  high from the cycle after acceptance until the cycle mark_done or err is high, inclusive.
REQ-011 mark_done  output  1  single-cycle pulse; line_count and win are valid this cycle.
REQ-012 err  output  1  single-cycle pulse for a rejected number.
REQ-013 line_count  output  4  completed lines, 0..12.
REQ-014 win  output  1  line_count >= WIN_LINES; sticky until start_game or reset.

Function
REQ-015 States: IDLE, LOOKUP, COUNT, DONE.
REQ-016 IDLE: mark_valid at cycle T is accepted; the number is converted to binary (10*tens+units) and registered; the next state is LOOKUP.
REQ-017 mark_valid outside IDLE is ignored; requests are not queued.
REQ-018 LOOKUP at T+1: reject if either digit > 9, the number is 0, the number is > 25, the looked-up position is > 24, or the position is already marked; on reject, err = 1 at T+2, state IDLE at T+2, marked unchanged.
REQ-019 LOOKUP accept: set marked[pos] at the end of T+1; then go to COUNT with line index 0 and accumulator 0.
REQ-020 COUNT: one line per cycle; indices 0-4 are rows, 5-9 are columns, 10 is the main diagonal (0,6,12,18,24), 11 is the anti-diagonal (4,8,12,16,20); a line counts when all five of its bits are marked.
REQ-021 COUNT ends after the last enabled line index, then goes to DONE.
REQ-022 DONE: load line_count from the accumulator, update win, pulse mark_done for one cycle, return to IDLE.
REQ-023 Latency with diagonals: mark_done at T+14. Latency without diagonals: mark_done at T+12.
REQ-024 A new mark_valid is accepted in the cycle after mark_done or err.
REQ-025 line_count is recomputed from scratch each pass; it never decrements within a game.
REQ-026 start_game has priority over mark_valid in the same cycle.
REQ-027 start_game in any state: marked, line_count, win and accumulator cleared next cycle; state IDLE; no mark_done or err for the aborted request.
REQ-028 The num_to_pos value sampled in LOOKUP is used; later changes do not affect that request.

Reset
REQ-029 On rst or interboard_rst: state IDLE, marked = 0, line_count = 0, win = 0, busy = 0, mark_done = 0, err = 0, line index and accumulator = 0.
REQ-030 Reset mid-operation discards the request; no pulse is emitted.

Configuration
REQ-031 Macro BINGO_DIAG_EN defined: 12 lines are checked (indices 0-11).
REQ-032 Macro BINGO_DIAG_EN undefined: only rows and columns are checked (indices 0-9); line_count max 10; the latency of REQ-023 applies.

Structure
REQ-033 Shared package bingo_pkg holds:
- constants N_CELLS = 25, CELL_W = 5, N_LINES = 12
- the state enum
- 25-bit line mask constants
REQ-034 One combinational sub-module, bingo_line_mask: line index (4 bits) in, 25-bit mask out.

Verification
REQ-035 Identity num_to_pos (n -> n-1); mark BCD 0x01..0x05 in turn -> after the fifth mark, mark_done at T+14, line_count = 1, win = 0.
REQ-036 Mark 1,7,13,19,25 under identity mapping -> line_count = 1 with BINGO_DIAG_EN, 0 without.
REQ-037 Inputs 0x00, 0x26, 0x1A, then 0x01 twice -> err pulse at T+2 for 0x00, 0x26, 0x1A and the second 0x01; marked = 0x0000001.
REQ-038 Mark all 25 numbers -> line_count = 12, win = 1 (WIN_LINES = 5); mark_valid while busy is ignored.
REQ-039 start_game asserted during COUNT -> next cycle marked = 0, line_count = 0, win = 0, no mark_done; assert interboard_rst mid-LOOKUP -> all outputs 0.

Source files
------------

// File: rtl/bingo_pkg.sv
// Shared constants, state encoding and line masks for the bingo marking logic.
package bingo_pkg;

  localparam int N_CELLS = 25;
  localparam int CELL_W  = 5;
  localparam int N_LINES = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Board positions are row-major; bit p of a mask is position p.
  localparam logic [24:0] ROW0_MASK = 25'h000001F;
  localparam logic [24:0] COL0_MASK = 25'h0108421;
  localparam logic [24:0] DIAG_MASK = 25'h1041041;
  localparam logic [24:0] ANTI_MASK = 25'h0111110;

  function automatic logic [7:0] bcd_to_bin(input logic [7:0] bcd);
    return ({4'd0, bcd[7:4]} * 8'd10) + {4'd0, bcd[3:0]};
  endfunction

endpackage

// File: rtl/bingo_line_mask.sv
// Maps a line index (0-4 rows, 5-9 columns, 10 diagonal, 11 anti-diagonal) to its cell mask.
module bingo_line_mask
  import bingo_pkg::*;
(
  input  logic [3:0]  line_idx,
  output logic [24:0] mask
);

  always_comb begin
    mask = '0;
    case (line_idx)
      4'd0:    mask = ROW0_MASK;
      4'd1:    mask = ROW0_MASK << 5;
      4'd2:    mask = ROW0_MASK << 10;
      4'd3:    mask = ROW0_MASK << 15;
      4'd4:    mask = ROW0_MASK << 20;
      4'd5:    mask = COL0_MASK;
      4'd6:    mask = COL0_MASK << 1;
      4'd7:    mask = COL0_MASK << 2;
      4'd8:    mask = COL0_MASK << 3;
      4'd9:    mask = COL0_MASK << 4;
      4'd10:   mask = DIAG_MASK;
      4'd11:   mask = ANTI_MASK;
      default: mask = '0;
    endcase
  end

endmodule

// File: rtl/handle_mark.sv
// Marks a called bingo number on the board, then scores completed lines one per cycle.
// Define BINGO_DIAG_EN to also score the two diagonals (12 lines instead of 10).
module handle_mark
  import bingo_pkg::*;
#(
  parameter int WIN_LINES = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         interboard_rst,
  input  logic         start_game,
  input  logic         mark_valid,
  input  logic [7:0]   mark_number_BCD,
  input  logic [124:0] num_to_pos,
  output logic [24:0]  marked,
  output logic         busy,
  output logic         mark_done,
  output logic         err,
  output logic [3:0]   line_count,
  output logic         win
);

`ifdef BINGO_DIAG_EN
  localparam logic [3:0] LAST_LINE = 4'd11;
`else
  localparam logic [3:0] LAST_LINE = 4'd9;
`endif

  state_e      state_q, state_d;
  logic [7:0]  num_q, num_d;
  logic        bcd_bad_q, bcd_bad_d;
  logic [24:0] marked_q, marked_d;
  logic [3:0]  line_idx_q, line_idx_d;
  logic [3:0]  acc_q, acc_d;
  logic [3:0]  line_count_q, line_count_d;
  logic        win_q, win_d;
  logic        err_q, err_d;

  logic [4:0]  lookup_pos;
  logic [24:0] pos_bit;
  logic        reject;
  logic [24:0] line_mask;
  logic        line_hit;

  bingo_line_mask u_line_mask (
    .line_idx (line_idx_q),
    .mask     (line_mask)
  );

  assign line_hit = (marked_q & line_mask) == line_mask;

  // Out-of-range numbers leave the position at 31, which the range check rejects.
  always_comb begin
    lookup_pos = '1;
    for (int i = 0; i < N_CELLS; i++) begin
      if (num_q == 8'(i + 1)) lookup_pos = num_to_pos[i*CELL_W +: CELL_W];
    end
    pos_bit = 25'd1 << lookup_pos;
    reject  = bcd_bad_q || (num_q == 8'd0) || (num_q > 8'd25) ||
              (lookup_pos > 5'd24) || ((marked_q & pos_bit) != '0);
  end

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    bcd_bad_d    = bcd_bad_q;
    marked_d     = marked_q;
    line_idx_d   = line_idx_q;
    acc_d        = acc_q;
    line_count_d = line_count_q;
    win_d        = win_q;
    err_d        = 1'b0;
    if (start_game) begin
      state_d      = ST_IDLE;
      marked_d     = '0;
      line_idx_d   = '0;
      acc_d        = '0;
      line_count_d = '0;
      win_d        = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mark_valid) begin
            num_d     = bcd_to_bin(mark_number_BCD);
            bcd_bad_d = (mark_number_BCD[7:4] > 4'd9) || (mark_number_BCD[3:0] > 4'd9);
            state_d   = ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (reject) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            marked_d   = marked_q | pos_bit;
            line_idx_d = '0;
            acc_d      = '0;
            state_d    = ST_COUNT;
          end
        end
        ST_COUNT: begin
          acc_d = acc_q + {3'd0, line_hit};
          // Results are loaded on the way into DONE so they are valid alongside mark_done.
          if (line_idx_q == LAST_LINE) begin
            line_count_d = acc_d;
            win_d        = win_q || (int'(acc_d) >= WIN_LINES);
            state_d      = ST_DONE;
          end else begin
            line_idx_d = line_idx_q + 4'd1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || interboard_rst) begin
      state_q      <= ST_IDLE;
      num_q        <= '0;
      bcd_bad_q    <= 1'b0;
      marked_q     <= '0;
      line_idx_q   <= '0;
      acc_q        <= '0;
      line_count_q <= '0;
      win_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      bcd_bad_q    <= bcd_bad_d;
      marked_q     <= marked_d;
      line_idx_q   <= line_idx_d;
      acc_q        <= acc_d;
      line_count_q <= line_count_d;
      win_q        <= win_d;
      err_q        <= err_d;
    end
  end

  // A reject returns to IDLE while err pulses, so busy also covers the err cycle.
  assign busy       = (state_q != ST_IDLE) || err_q;
  assign mark_done  = (state_q == ST_DONE);
  assign err        = err_q;
  assign marked     = marked_q;
  assign line_count = line_count_q;
  assign win        = win_q;

endmodule

// File: tb/tb_handle_mark.sv
// Self-checking bench for handle_mark against a board-level reference model.
// Honours BINGO_DIAG_EN to match the build of the design.
module tb_handle_mark;

  localparam int WIN = 5;
`ifdef BINGO_DIAG_EN
  localparam int EXP_LAT    = 14;
  localparam int FULL_LINES = 12;
  localparam int DIAG_LINES = 1;
`else
  localparam int EXP_LAT    = 12;
  localparam int FULL_LINES = 10;
  localparam int DIAG_LINES = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         interboard_rst = 1'b0;
  logic         start_game = 1'b0;
  logic         mark_valid = 1'b0;
  logic [7:0]   mark_number_BCD = '0;
  logic [124:0] num_to_pos = '0;
  logic [24:0]  marked;
  logic         busy, mark_done, err, win;
  logic [3:0]   line_count;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [24:0] m_marked;
  int          m_lines;
  bit          m_win;

  handle_mark #(.WIN_LINES(WIN)) dut (
    .clk             (clk),
    .rst             (rst),
    .interboard_rst  (interboard_rst),
    .start_game      (start_game),
    .mark_valid      (mark_valid),
    .mark_number_BCD (mark_number_BCD),
    .num_to_pos      (num_to_pos),
    .marked          (marked),
    .busy            (busy),
    .mark_done       (mark_done),
    .err             (err),
    .line_count      (line_count),
    .win             (win)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd_of(input int n);
    logic [7:0] b;
    b[7:4] = 4'(n / 10);
    b[3:0] = 4'(n % 10);
    return b;
  endfunction

  function automatic logic [124:0] identity_map();
    logic [124:0] m;
    m = '0;
    for (int n = 0; n < 25; n++) m[n*5 +: 5] = 5'(n);
    return m;
  endfunction

  function automatic logic [124:0] perm_map();
    int p[25];
    int j, t;
    logic [124:0] m;
    for (int i = 0; i < 25; i++) p[i] = i;
    for (int i = 24; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    m = '0;
    for (int i = 0; i < 25; i++) m[i*5 +: 5] = 5'(p[i]);
    return m;
  endfunction

  function automatic logic [124:0] garbage_map();
    logic [127:0] g;
    g = {$urandom, $urandom, $urandom, $urandom};
    return g[124:0];
  endfunction

  // Counts complete lines by walking each line's cells explicitly.
  function automatic int model_lines(input logic [24:0] m);
    int cnt;
    bit full;
    cnt = 0;
    for (int r = 0; r < 5; r++) begin
      full = 1;
      for (int k = 0; k < 5; k++) if (!m[r*5 + k]) full = 0;
      cnt += int'(full);
    end
    for (int c = 0; c < 5; c++) begin
      full = 1;
      for (int k = 0; k < 5; k++) if (!m[k*5 + c]) full = 0;
      cnt += int'(full);
    end
`ifdef BINGO_DIAG_EN
    full = 1;
    for (int k = 0; k < 5; k++) if (!m[k*6]) full = 0;
    cnt += int'(full);
    full = 1;
    for (int k = 0; k < 5; k++) if (!m[4 + 4*k]) full = 0;
    cnt += int'(full);
`endif
    return cnt;
  endfunction

  task automatic model_clear();
    m_marked = '0;
    m_lines  = 0;
    m_win    = 0;
  endtask

  task automatic new_game();
    start_game = 1'b1;
    cycle();
    start_game = 1'b0;
    model_clear();
  endtask

  // Issues one request, predicts its outcome and checks timing and results.
  task automatic do_mark(input logic [7:0] bcd, input logic [124:0] map, input bit noisy);
    int tens, units, n, pos, lat;
    bit rej;
    logic [124:0] sh;
    tens = int'(bcd[7:4]);
    units = int'(bcd[3:0]);
    n = tens * 10 + units;
    rej = (tens > 9) || (units > 9) || (n == 0) || (n > 25);
    pos = 0;
    if (!rej) begin
      sh = map >> ((n - 1) * 5);
      pos = int'(sh[4:0]);
      rej = (pos > 24) || m_marked[pos];
    end
    if (!rej) begin
      m_marked[pos] = 1'b1;
      m_lines = model_lines(m_marked);
      if (m_lines >= WIN) m_win = 1;
    end
    mark_valid = 1'b1;
    mark_number_BCD = bcd;
    num_to_pos = map;
    cycle();
    mark_valid = 1'b0;
    n_compared++;
    if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL busy_t1 bcd=%h got=%b want=1", bcd, busy); end
    cycle();
    num_to_pos = garbage_map();
    lat = 2;
    if (rej) begin
      n_compared++;
      if (err !== 1'b1 || mark_done !== 1'b0 || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL err_pulse bcd=%h got err=%b done=%b busy=%b want 1 0 1", bcd, err, mark_done, busy); end
      n_compared++;
      if (marked !== m_marked) begin n_mismatched++; $display("[TB] FAIL marked_rej bcd=%h got=%h want=%h", bcd, marked, m_marked); end
      cycle();
      n_compared++;
      if (err !== 1'b0 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL err_end bcd=%h got err=%b busy=%b want 0 0", bcd, err, busy); end
    end else begin
      n_compared++;
      if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL no_err bcd=%h got=%b want=0", bcd, err); end
      while (!mark_done && !err && lat < 30) begin
        if (noisy) begin
          mark_valid = 1'($urandom_range(0, 1));
          mark_number_BCD = bcd_of($urandom_range(1, 25));
        end
        cycle();
        lat++;
      end
      mark_valid = 1'b0;
      n_compared++;
      if (lat !== EXP_LAT || err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL latency bcd=%h got=%0d err=%b want=%0d", bcd, lat, err, EXP_LAT); end
      n_compared++;
      if (line_count !== 4'(m_lines) || win !== m_win) begin n_mismatched++; $display("[TB] FAIL result bcd=%h got lines=%0d win=%b want lines=%0d win=%b", bcd, line_count, win, m_lines, m_win); end
      n_compared++;
      if (marked !== m_marked || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL marked_ok bcd=%h got=%h busy=%b want=%h busy=1", bcd, marked, busy, m_marked); end
      cycle();
      n_compared++;
      if (mark_done !== 1'b0 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL done_end bcd=%h got done=%b busy=%b want 0 0", bcd, mark_done, busy); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mark_valid = 1'b1;
    mark_number_BCD = 8'h01;
    num_to_pos = identity_map();
    repeat (3) cycle();
    n_compared++;
    if ({marked, line_count, win, busy, mark_done, err} !== '0) begin n_mismatched++; $display("[TB] FAIL reset_state got marked=%h lines=%0d win=%b busy=%b done=%b err=%b want all 0", marked, line_count, win, busy, mark_done, err); end
    rst = 1'b0;
    mark_valid = 1'b0;
    cycle();
    n_compared++;
    if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_release got busy=%b want=0", busy); end
    model_clear();
  endtask

  task automatic test_row();
    new_game();
    for (int n = 1; n <= 5; n++) do_mark(bcd_of(n), identity_map(), 1'b0);
    n_compared++;
    if (line_count !== 4'd1 || win !== 1'b0) begin n_mismatched++; $display("[TB] FAIL row0 got lines=%0d win=%b want 1 0", line_count, win); end
  endtask

  task automatic test_diag();
    new_game();
    for (int k = 0; k < 5; k++) do_mark(bcd_of(1 + 6*k), identity_map(), 1'b0);
    n_compared++;
    if (line_count !== 4'(DIAG_LINES)) begin n_mismatched++; $display("[TB] FAIL diag got=%0d want=%0d", line_count, DIAG_LINES); end
  endtask

  task automatic test_errors();
    new_game();
    do_mark(8'h00, identity_map(), 1'b0);
    do_mark(8'h26, identity_map(), 1'b0);
    do_mark(8'h1A, identity_map(), 1'b0);
    do_mark(8'h01, identity_map(), 1'b0);
    do_mark(8'h01, identity_map(), 1'b0);
    n_compared++;
    if (marked !== 25'h0000001) begin n_mismatched++; $display("[TB] FAIL err_marked got=%h want=0000001", marked); end
  endtask

  task automatic test_full_board();
    int order[25];
    int j, t;
    logic [124:0] map;
    new_game();
    map = perm_map();
    for (int i = 0; i < 25; i++) order[i] = i + 1;
    for (int i = 24; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 25; i++) do_mark(bcd_of(order[i]), map, 1'b1);
    n_compared++;
    if (line_count !== 4'(FULL_LINES) || win !== 1'b1 || marked !== 25'h1FFFFFF) begin n_mismatched++; $display("[TB] FAIL full_board got lines=%0d win=%b marked=%h want %0d 1 1ffffff", line_count, win, marked, FULL_LINES); end
  endtask

  task automatic test_start_lookup();
    mark_valid = 1'b1;
    mark_number_BCD = 8'h01;
    num_to_pos = identity_map();
    cycle();
    mark_valid = 1'b0;
    start_game = 1'b1;
    cycle();
    start_game = 1'b0;
    model_clear();
    n_compared++;
    if ({marked, line_count, win, busy, mark_done, err} !== '0) begin n_mismatched++; $display("[TB] FAIL start_lookup got marked=%h lines=%0d win=%b busy=%b done=%b err=%b want all 0", marked, line_count, win, busy, mark_done, err); end
  endtask

  task automatic test_start_count();
    int pulses;
    new_game();
    for (int n = 1; n <= 4; n++) do_mark(bcd_of(n), identity_map(), 1'b0);
    mark_valid = 1'b1;
    mark_number_BCD = 8'h05;
    cycle();
    mark_valid = 1'b0;
    repeat (3) cycle();
    start_game = 1'b1;
    cycle();
    start_game = 1'b0;
    model_clear();
    n_compared++;
    if ({marked, line_count, win, busy, mark_done, err} !== '0) begin n_mismatched++; $display("[TB] FAIL start_count got marked=%h lines=%0d win=%b busy=%b done=%b err=%b want all 0", marked, line_count, win, busy, mark_done, err); end
    pulses = 0;
    repeat (16) begin
      if (mark_done || err) pulses++;
      cycle();
    end
    n_compared++;
    if (pulses != 0) begin n_mismatched++; $display("[TB] FAIL start_count_pulse got=%0d want=0", pulses); end
    do_mark(8'h05, identity_map(), 1'b0);
  endtask

  task automatic test_start_priority();
    int pulses;
    start_game = 1'b1;
    mark_valid = 1'b1;
    mark_number_BCD = 8'h03;
    num_to_pos = identity_map();
    cycle();
    start_game = 1'b0;
    mark_valid = 1'b0;
    model_clear();
    pulses = 0;
    repeat (16) begin
      if (mark_done || err || busy) pulses++;
      cycle();
    end
    n_compared++;
    if (pulses != 0 || marked !== 25'h0) begin n_mismatched++; $display("[TB] FAIL start_priority got activity=%0d marked=%h want 0 0", pulses, marked); end
  endtask

  task automatic test_interboard();
    int pulses;
    new_game();
    for (int n = 1; n <= 5; n++) do_mark(bcd_of(n), identity_map(), 1'b0);
    mark_valid = 1'b1;
    mark_number_BCD = 8'h06;
    cycle();
    mark_valid = 1'b0;
    interboard_rst = 1'b1;
    cycle();
    interboard_rst = 1'b0;
    model_clear();
    n_compared++;
    if ({marked, line_count, win, busy, mark_done, err} !== '0) begin n_mismatched++; $display("[TB] FAIL interboard got marked=%h lines=%0d win=%b busy=%b done=%b err=%b want all 0", marked, line_count, win, busy, mark_done, err); end
    pulses = 0;
    repeat (16) begin
      if (mark_done || err) pulses++;
      cycle();
    end
    n_compared++;
    if (pulses != 0) begin n_mismatched++; $display("[TB] FAIL interboard_pulse got=%0d want=0", pulses); end
    do_mark(8'h06, identity_map(), 1'b0);
  endtask

  task automatic test_random();
    logic [124:0] map;
    logic [7:0] bcd;
    for (int g = 0; g < 3; g++) begin
      new_game();
      map = perm_map();
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 9) == 0) bcd = 8'($urandom);
        else bcd = bcd_of($urandom_range(1, 25));
        if ($urandom_range(0, 9) == 0) do_mark(bcd, garbage_map(), 1'b1);
        else do_mark(bcd, map, 1'b1);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_row();
    test_diag();
    test_errors();
    test_full_board();
    test_start_lookup();
    test_start_count();
    test_start_priority();
    test_interboard();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
